// File: rtl/rate_limiter_pacer.sv
// rate_limiter_pacer: passes a packet stream and pauses upstream for (word count << shift) cycles after each packet
// Ports: clk/reset (sync, active-high); in_data/in_ctrl/in_wr/in_rdy upstream; out_data/out_ctrl/out_wr/out_rdy downstream;
// thruput_shift[3:0] and enable_rate_limit from the register block, sampled at EOP; pause_active high while pausing.
module rate_limiter_pacer #(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter int CNT_WIDTH   = 16,
  parameter int PAUSE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [15:0]           thruput_shift,
  input  logic                  enable_rate_limit,
  output logic                  pause_active
);
  localparam logic [1:0] HDR = 2'd0, PAYLOAD = 2'd1, PAUSE = 2'd2;
  logic [1:0]             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [PAUSE_WIDTH-1:0] r_pause;
  logic                   r_out_wr;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [CTRL_WIDTH-1:0]  r_out_ctrl;
  logic                   w_acc, w_eop, w_unused;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic [PAUSE_WIDTH-1:0] w_pause_len, w_pause_dec;
  assign in_rdy       = out_rdy & (r_state != PAUSE);
  assign w_acc        = in_wr & in_rdy;
  assign w_eop        = (in_ctrl != '0) && (in_ctrl != '1);
  // count includes the word being accepted and sticks at all-ones
  assign w_cnt_inc    = &r_cnt ? r_cnt : r_cnt + CNT_WIDTH'(1);
  assign w_pause_len  = PAUSE_WIDTH'(w_cnt_inc) << thruput_shift[3:0];
  assign w_pause_dec  = r_pause - PAUSE_WIDTH'(1);
  assign w_unused     = ^thruput_shift[15:4];
  assign out_wr       = r_out_wr;
  assign out_data     = r_out_data;
  assign out_ctrl     = r_out_ctrl;
  assign pause_active = r_state == PAUSE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= HDR;
      r_cnt      <= '0;
      r_pause    <= '0;
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_ctrl <= '0;
    end else begin
      r_out_wr <= w_acc;
      if (w_acc) begin
        r_out_data <= in_data;
        r_out_ctrl <= in_ctrl;
      end
      if (r_state == PAUSE) begin
        // dropping the enable aborts the pause outright
        r_pause <= enable_rate_limit ? w_pause_dec : '0;
        if (!enable_rate_limit || w_pause_dec == '0) r_state <= HDR;
      end else if (w_acc) begin
        if (r_state == PAYLOAD && w_eop) begin
          r_cnt   <= '0;
          r_pause <= enable_rate_limit ? w_pause_len : '0;
          r_state <= enable_rate_limit ? PAUSE : HDR;
        end else begin
          r_cnt <= w_cnt_inc;
          if (r_state == HDR && in_ctrl == '0) r_state <= PAYLOAD;
        end
      end
    end
  end
endmodule

// File: tb/tb_rate_limiter_pacer.sv
// tb_rate_limiter_pacer: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_rate_limiter_pacer;
  logic        clk = 0, reset = 1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 0, in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr, out_rdy = 1;
  logic [15:0] thruput_shift = '0;
  logic        enable_rate_limit = 0, pause_active;
  int total = 0, bad = 0, outw = 0;
  bit rnd = 0, seen = 0;
  int m_pause = 0, m_words = 0;
  bit m_payload = 0, m_out_wr = 0;
  logic [63:0] m_data = '0;
  logic [7:0]  m_ctrl = '0;

  rate_limiter_pacer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .thruput_shift(thruput_shift), .enable_rate_limit(enable_rate_limit), .pause_active(pause_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: inputs are stable from negedge to the next posedge, so the state after that edge is computed here
  always @(negedge clk) begin
    bit exp_rdy, acc;
    longint p;
    exp_rdy = out_rdy && m_pause == 0;
    if (seen) begin
      chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      chk("pause_active", 64'(pause_active), 64'(m_pause > 0));
      chk("out_wr", 64'(out_wr), 64'(m_out_wr));
      chk("out_data", out_data, m_data);
      chk("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
      if (out_wr) outw++;
    end
    acc = in_wr && exp_rdy;
    if (reset) begin
      seen = 1; m_pause = 0; m_words = 0; m_payload = 0; m_out_wr = 0; m_data = '0; m_ctrl = '0;
    end else begin
      m_out_wr = acc;
      if (acc) begin m_data = in_data; m_ctrl = in_ctrl; end
      if (m_pause > 0) m_pause = enable_rate_limit ? m_pause - 1 : 0;
      else if (acc) begin
        m_words = m_words < 65535 ? m_words + 1 : 65535;
        if (!m_payload && in_ctrl == 8'h00) m_payload = 1;
        else if (m_payload && in_ctrl != 8'h00 && in_ctrl != 8'hFF) begin
          p = longint'(m_words) << thruput_shift[3:0];
          m_payload = 0; m_words = 0;
          if (enable_rate_limit) m_pause = int'(p);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int n = 0;
    bit done = 0;
    in_ctrl = c;
    in_data = {$urandom, $urandom};
    if (rnd) enable_rate_limit = ($urandom % 10) != 0;
    while (!done) begin
      if (rnd) out_rdy = ($urandom % 4) != 0;
      #1;
      if (in_rdy) done = 1;
      else if (n >= 3000) begin chk("send_timeout", 64'(n), 64'(0)); done = 1; end
      else begin @(posedge clk); #1; n++; end
    end
    in_wr = in_rdy;
    @(posedge clk); #1;
    in_wr = 0;
  endtask

  task automatic measure(output int n);
    n = 0;
    while (!in_rdy && n < 5000) begin @(posedge clk); #1; n++; end
    if (n >= 5000) chk("pause_timeout", 64'(n), 64'(0));
  endtask

  task automatic pkt4(input logic [7:0] eop);
    send(8'hFF); send(8'h00); send(8'h00); send(eop);
  endtask

  task automatic pulse_reset;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_in_rdy", 64'(in_rdy), 64'(1));
    chk("rst_pause", 64'(pause_active), 64'(0));
    chk("rst_out_wr", 64'(out_wr), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
  endtask

  initial begin
    int n, c0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_pause", 64'(pause_active), 64'(0));
    chk("reset_out_wr", 64'(out_wr), 64'(0));
    // pass-through, no pauses
    c0 = outw;
    pkt4(8'h0F);
    chk("pt_in_rdy", 64'(in_rdy), 64'(1));
    @(posedge clk); #1;
    chk("pt_out_wr_count", 64'(outw - c0), 64'(4));
    chk("pt_last_ctrl", 64'(out_ctrl), 64'(8'h0F));
    // 4 words << 2
    enable_rate_limit = 1; thruput_shift = 16'd2;
    pkt4(8'h0F);
    chk("p16_active", 64'(pause_active), 64'(1));
    measure(n);
    chk("pause_16", 64'(n), 64'(16));
    // 3 words << 0, next packet accepted straight after
    thruput_shift = 16'd0;
    send(8'hFF); send(8'h00); send(8'h01);
    measure(n);
    chk("pause_3", 64'(n), 64'(3));
    chk("next_ready", 64'(in_rdy), 64'(1));
    // abort a 64-cycle pause five cycles in
    thruput_shift = 16'd4;
    pkt4(8'h0F);
    repeat (5) @(posedge clk);
    #1 enable_rate_limit = 0;
    measure(n);
    chk("abort_cycles", 64'(n), 64'(1));
    chk("abort_active", 64'(pause_active), 64'(0));
    enable_rate_limit = 1;
    // shift changed mid-packet, upper shift bits ignored
    thruput_shift = 16'hFFF1;
    send(8'hFF); send(8'h00); send(8'h00);
    thruput_shift = 16'hA003;
    send(8'h0F);
    measure(n);
    chk("pause_shift3", 64'(n), 64'(32));
    pkt4(8'h03);
    measure(n);
    chk("pause_shift3_next", 64'(n), 64'(32));
    // reset during pause, then mid-payload
    thruput_shift = 16'd2;
    pkt4(8'h0F);
    repeat (3) @(posedge clk);
    #1 pulse_reset();
    thruput_shift = 16'd0;
    send(8'hFF); send(8'h00); send(8'h0F);
    measure(n);
    chk("post_rst_pause", 64'(n), 64'(3));
    send(8'hFF); send(8'h00);
    pulse_reset();
    send(8'hFF); send(8'h00); send(8'h0F);
    measure(n);
    chk("post_rst_count", 64'(n), 64'(3));
    // randomized traffic
    rnd = 1;
    repeat (150) begin
      thruput_shift = {12'($urandom), 4'($urandom_range(0, 3))};
      repeat ($urandom_range(1, 2)) send(8'hFF);
      send(8'h00);
      repeat ($urandom_range(0, 4)) send(8'h00);
      send(8'($urandom_range(1, 254)));
      repeat ($urandom_range(0, 5)) begin out_rdy = ($urandom % 4) != 0; @(posedge clk); #1; end
    end
    rnd = 0; out_rdy = 1; enable_rate_limit = 1;
    repeat (300) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
